blit_scheduler: RTL and testbench
=================================

# blit_scheduler

Frame-synchronous command scheduler for the sprite copy engine. Software (or the game-logic FSM) queues rectangular blit commands; at each frame start the block drains its queue into the copy engine one command at a time, with screen clipping and a start/done handshake. It sits between the command producer and the copy engine's job port. It owns no SDRAM or frame-buffer traffic itself.

## Interface
- DEPTH, 8: command FIFO depth, power of two, ≥2
- SCREEN_W, 640: visible width in pixels
- SCREEN_H, 480: visible height in pixels

Ports:
- Clk  in  1  single system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present on cmd_* fields
- cmd_ready  out  1  FIFO can accept; push occurs when cmd_valid & cmd_ready
- cmd_src_addr  in  22  sprite base address in source memory
- cmd_x, cmd_y  in  10 each  destination top-left
- cmd_w, cmd_h  in  10 each  sprite width/height
- cmd_palette  in  2  palette index
- frame_start  in  1  one-cycle pulse at start of vertical blank
- eng_start  out  1  one-cycle job-start pulse to copy engine
- eng_src_addr  out  22  job source address
- eng_x, eng_y, eng_w, eng_h  out  10 each  clipped job geometry
- eng_palette  out  2  job palette index
- eng_done  in  1  one-cycle pulse from engine when job finished
- busy  out  1  high in any state other than IDLE
- overrun  out  1  one-cycle pulse: frame_start arrived while busy
- pending  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO: DEPTH entries of {src_addr, x, y, w, h, palette}; cmd_ready = !full; simultaneous push and pop permitted, occupancy unchanged.
- FSM states IDLE, LOAD, ISSUE, WAIT.
- IDLE: on frame_start & !empty -> LOAD. frame_start with empty FIFO ignored, no overrun.
- LOAD: pop head into job registers, apply clip; if job dropped -> LOAD if FIFO still non-empty else IDLE; otherwise -> ISSUE.
- ISSUE: eng_start=1 for exactly one cycle -> WAIT.
- WAIT: on eng_done -> LOAD if !empty else IDLE. Commands pushed during a drain are drawn in the same frame.
- Clip rules (11-bit arithmetic, no overflow): drop if w==0, h==0, x≥SCREEN_W or y≥SCREEN_H; if x+w>SCREEN_W, eng_w=SCREEN_W−x; if y+h>SCREEN_H, eng_h=SCREEN_H−y. src_addr, x, y, palette pass unchanged.
- frame_start while busy: pulse overrun next cycle; drain continues uninterrupted; the frame_start is otherwise discarded.
- eng_done outside WAIT is ignored.

## Timing
- Reset: FIFO emptied, state IDLE; outputs: cmd_ready=1, eng_start=0, eng_* fields=0, busy=0, overrun=0, pending=0. Reset mid-job aborts without waiting for eng_done; copy engine shares the same Reset.
- frame_start at cycle N (IDLE, non-empty) -> LOAD at N+1 -> eng_start high at N+2.
- eng_done at cycle M -> next eng_start at M+2 (LOAD, ISSUE) if next head is valid; each dropped command adds one LOAD cycle.
- eng_* fields registered, stable from eng_start cycle until the cycle after eng_done.
- pending and cmd_ready update the cycle after a push/pop.
- busy registered from state; overrun registered.

## Test plan
- Reset, push 3 commands (x=0,y=0,w=16,h=16), pulse frame_start -> three eng_start pulses, each 2 cycles after prior eng_done; busy falls after third eng_done, pending=0.
- Push x=630,w=32,y=470,h=32 -> eng_w=10, eng_h=10; push x=640 or w=0 -> no eng_start, FSM skips to next entry.
- Fill FIFO (8 pushes) -> cmd_ready=0, ninth cmd_valid not accepted, pending=8; push during pop in LOAD keeps pending constant.
- frame_start while in WAIT -> overrun pulses one cycle, current job and remaining queue complete normally.
- frame_start with empty FIFO -> busy stays 0, no eng_start, no overrun.
- Assert Reset during WAIT -> next cycle state IDLE, pending=0, eng_start=0; later eng_done ignored.

Source files
------------

// File: rtl/blit_scheduler.sv
// Frame-synchronous blit command scheduler: FIFO of copy jobs drained into the copy engine at each frame start.
// Latency: frame_start (idle, queue non-empty) -> eng_start two cycles later; eng_done -> next eng_start two cycles later, +1 per dropped job.
// Backpressure: cmd_ready deasserts while the FIFO is full; the engine paces the drain through eng_done.
module blit_scheduler #(
   parameter int DEPTH    = 8,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [21:0]              cmd_src_addr,
   input  logic [9:0]               cmd_x,
   input  logic [9:0]               cmd_y,
   input  logic [9:0]               cmd_w,
   input  logic [9:0]               cmd_h,
   input  logic [1:0]               cmd_palette,
   input  logic                     frame_start,
   output logic                     eng_start,
   output logic [21:0]              eng_src_addr,
   output logic [9:0]               eng_x,
   output logic [9:0]               eng_y,
   output logic [9:0]               eng_w,
   output logic [9:0]               eng_h,
   output logic [1:0]               eng_palette,
   input  logic                     eng_done,
   output logic                     busy,
   output logic                     overrun,
   output logic [$clog2(DEPTH):0]   pending
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [10:0]   SW11     = 11'(SCREEN_W);
   localparam logic [10:0]   SH11     = 11'(SCREEN_H);
   localparam logic [9:0]    SW10     = 10'(SCREEN_W);
   localparam logic [9:0]    SH10     = 10'(SCREEN_H);

   typedef struct packed {
      logic [21:0] src_addr;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [9:0]  w;
      logic [9:0]  h;
      logic [1:0]  palette;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT} state_t;

   cmd_t          mem [DEPTH];
   cmd_t          cmd_in;
   cmd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          push;
   logic          pop;
   state_t        state;

   logic          drop;
   logic [10:0]   x_end;
   logic [10:0]   y_end;
   logic [9:0]    clip_w;
   logic [9:0]    clip_h;

   assign cmd_in     = '{src_addr: cmd_src_addr, x: cmd_x, y: cmd_y,
                         w: cmd_w, h: cmd_h, palette: cmd_palette};
   assign cmd_ready  = (count != FULL_CNT);
   assign pending    = count;
   assign push       = cmd_valid && cmd_ready;
   // The head is only consumed in LOAD, and LOAD is only entered with a non-empty queue.
   assign pop        = (state == LOAD);
   assign head       = mem[rd_ptr];
   // Occupancy after this cycle; a command pushed now is already visible to the next LOAD,
   // which lets late arrivals still be drawn in the current frame.
   assign count_next = count + CW'(push) - CW'(pop);

   // Clipping is done in 11 bits so x+w and y+h never wrap.
   assign x_end  = {1'b0, head.x} + {1'b0, head.w};
   assign y_end  = {1'b0, head.y} + {1'b0, head.h};
   assign drop   = (head.w == 10'd0) || (head.h == 10'd0) ||
                   ({1'b0, head.x} >= SW11) || ({1'b0, head.y} >= SH11);
   assign clip_w = (x_end > SW11) ? (SW10 - head.x) : head.w;
   assign clip_h = (y_end > SH11) ? (SH10 - head.y) : head.h;

   // Command storage; contents need no reset because the pointers define validity.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr] <= cmd_in;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
      end
   end

   // Drain FSM with registered job fields, start pulse, busy and overrun flags.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         eng_start    <= 1'b0;
         eng_src_addr <= '0;
         eng_x        <= '0;
         eng_y        <= '0;
         eng_w        <= '0;
         eng_h        <= '0;
         eng_palette  <= '0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         overrun   <= frame_start && busy;
         case (state)
            IDLE: begin
               if (frame_start && (count != '0)) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               if (drop) begin
                  if (count_next != '0) begin
                     state <= LOAD;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  eng_src_addr <= head.src_addr;
                  eng_x        <= head.x;
                  eng_y        <= head.y;
                  eng_w        <= clip_w;
                  eng_h        <= clip_h;
                  eng_palette  <= head.palette;
                  eng_start    <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (eng_done) begin
                  if (count_next != '0) begin
                     state <= LOAD;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_blit_scheduler.sv
// Bench for blit_scheduler: directed scenarios plus randomized frames.
// Reference model: a queue of accepted commands; each frame drains it in order, clipping or dropping.
// Engine side is emulated with randomized eng_done delays.
module tb_blit_scheduler;

   localparam int SW = 640;
   localparam int SH = 480;

   typedef struct {
      logic [21:0] src;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [9:0]  w;
      logic [9:0]  h;
      logic [1:0]  pal;
   } tcmd_t;

   logic        clk;
   logic        Reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [21:0] cmd_src_addr;
   logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
   logic [1:0]  cmd_palette;
   logic        frame_start;
   logic        eng_start;
   logic [21:0] eng_src_addr;
   logic [9:0]  eng_x, eng_y, eng_w, eng_h;
   logic [1:0]  eng_palette;
   logic        eng_done;
   logic        busy;
   logic        overrun;
   logic [3:0]  pending;

   int    n_cmp  = 0;
   int    n_fail = 0;
   int    cyc    = 0;
   tcmd_t model_q[$];

   blit_scheduler #(.DEPTH(8), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
      .Clk(clk), .Reset(Reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src_addr(cmd_src_addr), .cmd_x(cmd_x), .cmd_y(cmd_y),
      .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_palette(cmd_palette),
      .frame_start(frame_start),
      .eng_start(eng_start), .eng_src_addr(eng_src_addr),
      .eng_x(eng_x), .eng_y(eng_y), .eng_w(eng_w), .eng_h(eng_h),
      .eng_palette(eng_palette), .eng_done(eng_done),
      .busy(busy), .overrun(overrun), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; the model records a push exactly when the DUT sees valid & ready at the edge.
   task automatic tick();
      logic  do_push;
      tcmd_t c;
      do_push = cmd_valid && cmd_ready;
      c = '{src: cmd_src_addr, x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, pal: cmd_palette};
      @(posedge clk);
      if (do_push) model_q.push_back(c);
      cyc++;
      #1;
   endtask

   function automatic bit is_drop(input tcmd_t c);
      return (c.w == 0) || (c.h == 0) || (int'(c.x) >= SW) || (int'(c.y) >= SH);
   endfunction

   function automatic int exp_w(input tcmd_t c);
      if (int'(c.x) + int'(c.w) > SW) return SW - int'(c.x);
      return int'(c.w);
   endfunction

   function automatic int exp_h(input tcmd_t c);
      if (int'(c.y) + int'(c.h) > SH) return SH - int'(c.y);
      return int'(c.h);
   endfunction

   function automatic tcmd_t mk(input int src, input int x, input int y, input int w, input int h);
      tcmd_t c;
      c.src = 22'(src); c.x = 10'(x); c.y = 10'(y); c.w = 10'(w); c.h = 10'(h); c.pal = 2'(src);
      return c;
   endfunction

   function automatic tcmd_t rand_cmd();
      tcmd_t c;
      c.src = 22'($urandom);
      c.x   = 10'($urandom_range(700, 0));
      c.y   = 10'($urandom_range(520, 0));
      c.w   = ($urandom_range(9, 0) == 0) ? 10'd0 : 10'($urandom_range(96, 1));
      c.h   = ($urandom_range(9, 0) == 0) ? 10'd0 : 10'($urandom_range(96, 1));
      c.pal = 2'($urandom);
      return c;
   endfunction

   task automatic drive_cmd(input tcmd_t c);
      cmd_src_addr = c.src; cmd_x = c.x; cmd_y = c.y;
      cmd_w = c.w; cmd_h = c.h; cmd_palette = c.pal;
   endtask

   task automatic push_cmd(input tcmd_t c);
      drive_cmd(c);
      cmd_valid = 1'b1;
      chk("push_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_frame(output int trig);
      trig = cyc;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // Emulates the engine through a whole drain and checks each job against the model queue.
   task automatic drain(input int trig_in, input int max_gap, input bit rnd_push,
                        input bit ovr_in, input bit load_push);
      int    trig, drops, target, g;
      bit    first, do_ovr, done;
      tcmd_t c;
      trig = trig_in; first = 1'b1; do_ovr = ovr_in; done = 1'b0;
      while (!done) begin
         drops = 0;
         while (model_q.size() > 0 && is_drop(model_q[0])) begin
            void'(model_q.pop_front());
            drops++;
         end
         if (model_q.size() == 0) begin
            target = trig + 1 + drops;
            while (cyc < target) begin
               chk("no_start_on_drop", eng_start, 0);
               tick();
            end
            chk("busy_fall", busy, 0);
            chk("pending_empty", pending, 0);
            chk("start_idle", eng_start, 0);
            done = 1'b1;
         end else begin
            c = model_q.pop_front();
            target = trig + 2 + drops;
            while (cyc < target) begin
               chk("start_early", eng_start, 0);
               if (first && load_push && cyc == trig + 1) begin
                  drive_cmd(rand_cmd());
                  cmd_valid = 1'b1;
               end
               tick();
               cmd_valid = 1'b0;
            end
            chk("eng_start", eng_start, 1);
            chk("eng_src", eng_src_addr, c.src);
            chk("eng_x", eng_x, c.x);
            chk("eng_y", eng_y, c.y);
            chk("eng_w", eng_w, exp_w(c));
            chk("eng_h", eng_h, exp_h(c));
            chk("eng_pal", eng_palette, c.pal);
            chk("pending_issue", pending, model_q.size());
            first = 1'b0;
            g = $urandom_range(max_gap, 1);
            for (int i = 0; i < g; i++) begin
               if (do_ovr && i == 0) frame_start = 1'b1;
               if (rnd_push && $urandom_range(2, 0) == 0) begin
                  drive_cmd(rand_cmd());
                  cmd_valid = 1'b1;
               end
               tick();
               cmd_valid = 1'b0;
               if (frame_start) begin
                  chk("overrun_pulse", overrun, 1);
                  frame_start = 1'b0;
                  do_ovr = 1'b0;
               end
               chk("busy_wait", busy, 1);
               chk("start_one_cycle", eng_start, 0);
               chk("pending_wait", pending, model_q.size());
               chk("ready_wait", cmd_ready, (model_q.size() < 8) ? 1 : 0);
               chk("fields_stable", eng_x, c.x);
            end
            eng_done = 1'b1;
            trig = cyc;
            tick();
            eng_done = 1'b0;
            chk("overrun_low", overrun, 0);
            chk("fields_after_done", eng_w, exp_w(c));
         end
      end
   endtask

   initial begin
      int trig;
      Reset = 1'b1; cmd_valid = 1'b0; frame_start = 1'b0; eng_done = 1'b0;
      drive_cmd(mk(0, 0, 0, 0, 0));
      tick(); tick(); tick();

      // Reset state
      chk("rst_ready", cmd_ready, 1);
      chk("rst_start", eng_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_pending", pending, 0);
      chk("rst_eng_x", eng_x, 0);
      chk("rst_eng_w", eng_w, 0);
      chk("rst_eng_src", eng_src_addr, 0);
      Reset = 1'b0;
      tick();

      // Three plain 16x16 jobs at the origin
      for (int i = 0; i < 3; i++) push_cmd(mk(100 + i, 0, 0, 16, 16));
      chk("pending_three", pending, 3);
      pulse_frame(trig);
      drain(trig, 3, 1'b0, 1'b0, 1'b0);

      // Clipping at the right/bottom edges and dropped commands in between
      push_cmd(mk(200, 630, 470, 32, 32));
      push_cmd(mk(201, 640, 10, 8, 8));
      push_cmd(mk(202, 10, 10, 0, 8));
      push_cmd(mk(203, 5, 479, 4, 4));
      push_cmd(mk(204, 1, 2, 3, 4));
      push_cmd(mk(205, 3, 480, 8, 8));
      pulse_frame(trig);
      drain(trig, 2, 1'b0, 1'b0, 1'b0);

      // Full FIFO refuses a ninth command; frame_start during WAIT flags overrun
      for (int i = 0; i < 8; i++) push_cmd(mk(300 + i, 8 * i, 4 * i, 20, 12));
      chk("full_ready", cmd_ready, 0);
      chk("full_pending", pending, 8);
      drive_cmd(mk(399, 1, 1, 1, 1));
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("ninth_refused", pending, 8);
      chk("ninth_model", pending, model_q.size());
      pulse_frame(trig);
      drain(trig, 3, 1'b0, 1'b1, 1'b0);

      // Push in the same cycle as the LOAD pop leaves occupancy unchanged
      push_cmd(mk(400, 50, 60, 30, 40));
      push_cmd(mk(401, 70, 80, 30, 40));
      pulse_frame(trig);
      drain(trig, 2, 1'b0, 1'b0, 1'b1);

      // frame_start with an empty queue does nothing
      chk("empty_pending", pending, 0);
      pulse_frame(trig);
      for (int i = 0; i < 3; i++) begin
         chk("empty_busy", busy, 0);
         chk("empty_start", eng_start, 0);
         chk("empty_overrun", overrun, 0);
         tick();
      end

      // Reset while waiting on the engine aborts the job; a late eng_done is ignored
      push_cmd(mk(500, 10, 10, 10, 10));
      push_cmd(mk(501, 20, 20, 10, 10));
      pulse_frame(trig);
      tick();
      chk("rw_start", eng_start, 1);
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      model_q.delete();
      chk("rw_busy", busy, 0);
      chk("rw_pending", pending, 0);
      chk("rw_start_low", eng_start, 0);
      chk("rw_eng_x", eng_x, 0);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      tick();
      chk("rw_done_ignored_busy", busy, 0);
      chk("rw_done_ignored_start", eng_start, 0);

      // Randomized frames with pushes and overruns during the drain
      for (int r = 0; r < 40; r++) begin
         int n;
         n = $urandom_range(8, 1);
         for (int i = 0; i < n; i++) push_cmd(rand_cmd());
         chk("rnd_pending", pending, model_q.size());
         pulse_frame(trig);
         drain(trig, 4, 1'b1, ($urandom_range(3, 0) == 0), 1'b0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
